// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle left shifter/rotator, one log2 stage per clock.
// Operands arrive on a valid/ready handshake; result, carry and zero flag
// leave on a second valid/ready handshake.
module shift_left_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  // Stage counter runs 0..SHW; the value SHW is the flag-settle step that
  // follows the last shift stage.
  localparam int KW = $clog2(SHW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   shamt_q;
  logic             rot_q;
  logic             carry_q;
  logic             zero_q;
  logic [KW-1:0]    stage;

  logic             accept;
  logic             last_step;
  logic             stage_en;
  logic [WIDTH-1:0] stage_val;
  logic             stage_carry;

  assign accept    = in_valid && in_ready;
  assign last_step = (stage == KW'(SHW));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed-latency walk through every stage, no early exit.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; in_ready is forced low in reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = !rst;
      SHIFT:   ;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Select the current stage: shift by 2^stage, wrap-around fill when rotating.
  // The carry is the bit that crosses the MSB; because stages apply in
  // ascending order, the last enabled stage always exposes in_a[WIDTH-shamt].
  always_comb begin
    stage_en    = 1'b0;
    stage_val   = work;
    stage_carry = carry_q;
    for (int unsigned i = 0; i < SHW; i++) begin
      if (stage == KW'(i)) begin
        stage_en    = shamt_q[i];
        stage_val   = (work << (1 << i)) |
                      (rot_q ? (work >> (WIDTH - (1 << i))) : '0);
        stage_carry = work[WIDTH - (1 << i)];
      end
    end
  end

  // Datapath: operand capture, per-stage update, zero flag after the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      shamt_q <= '0;
      rot_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      stage   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            work    <= in_a;
            shamt_q <= in_shamt;
            rot_q   <= in_rot;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            stage   <= '0;
          end
        end
        SHIFT: begin
          if (last_step) begin
            zero_q <= (work == '0);
          end else begin
            if (stage_en) begin
              work    <= stage_val;
              carry_q <= stage_carry;
            end
            stage <= stage + 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign out_data  = work;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;

endmodule
